pbus_mc_bridge: RTL and testbench
=================================

Name: pbus_mc_bridge

Overview:
Parametrised successor to the single-target APB-like bridge. It converts one 32-bit APB-like slave port into NUM_CH independent 16-bit IP register channels, for example ptpv2 core, rx converter and tx converter stats. Features beyond the single-target bridge: channel address decode, per-channel IP acknowledge with timeout, decode/timeout slave error, and a saturating error counter. It sits between the SoC peripheral bus and the ptpv2 core plus its companion IPs in the core wrapper.

Parameters:
NUM_CH, 4, number of IP channels (1..16)
DATA_W, 16, IP data width (<=32); write data = pbus_wdata_i[DATA_W-1:0]
ADDR_W, 16, IP local address width; bus2ip_addr_o = pbus_addr_i[ADDR_W-1:0]
CH_LSB, 16, LSB of channel-select field in pbus_addr_i; field width CH_W = max(1, clog2(NUM_CH))
TIMEOUT, 15, cycles after ce pulse without ack before slverr (>=1)
ERRCNT_W, 8, width of saturating error counter

Ports:
pbus_clk  in  1  sole clock
pbus_rst  in  1  asynchronous reset, active-high
pbus_addr_i  in  32  APB address
pbus_write_i  in  1  1=write
pbus_sel_i  in  1  slave select
pbus_enable_i  in  1  access phase
pbus_wdata_i  in  32  write data
pbus_rdata_o  out  32  read data, zero-extended, valid when pbus_ready_o=1
pbus_ready_o  out  1  transfer complete, one-cycle pulse
pbus_slverr_o  out  1  error qualifier, valid with pbus_ready_o
bus2ip_addr_o  out  ADDR_W  shared latched local address
bus2ip_data_o  out  DATA_W  shared latched write data
bus2ip_rd_ce_o  out  NUM_CH  one-hot read strobe, one cycle
bus2ip_wr_ce_o  out  NUM_CH  one-hot write strobe, one cycle
ip2bus_data_i  in  NUM_CH*DATA_W  channel k data at [k*DATA_W +: DATA_W]
ip2bus_ack_i  in  NUM_CH  channel k done; read data valid in same cycle
err_cnt_o  out  ERRCNT_W  saturating count of slverr responses
last_err_o  out  2  {timeout, decode} cause of the most recent error

Behaviour:
- Reset (pbus_rst=1, async): state IDLE; all outputs 0; counters 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on pbus_sel_i & pbus_enable_i, latch addr, wdata, write and ch = pbus_addr_i[CH_LSB +: CH_W].
  - If ch >= NUM_CH or pbus_addr_i[1:0] != 0: go to RESP with slverr=1, decode=1, no strobe.
  - Otherwise go to REQ.
- REQ (exactly 1 cycle): assert bus2ip_rd_ce_o[ch] or bus2ip_wr_ce_o[ch]; all other ce bits are 0. Clear timeout counter.
  - If ip2bus_ack_i[ch]=1 in this cycle: go to RESP.
  - Else: go to WAIT.
- WAIT: no strobes; counter increments each cycle.
  - If ip2bus_ack_i[ch]: go to RESP with slverr=0.
  - Else when counter reaches TIMEOUT-1: go to RESP with slverr=1, timeout=1, rdata=0.
- RESP: pbus_ready_o=1 for exactly one cycle, then IDLE.
  - Read with ack: pbus_rdata_o = zero-extended ip2bus_data_i slice captured on the ack cycle.
  - Write or error: pbus_rdata_o = 0.
- Latency, from the first access cycle T: decode error gives ready at T+1; ack in REQ gives ready at T+2; timeout gives ready at T+1+TIMEOUT.
- Acks from non-selected channels, or acks in IDLE/RESP, are ignored.
- pbus_sel_i dropping in REQ or WAIT (protocol abort): go to IDLE next cycle; no ready; no error count. A late ack is ignored.
- IDLE is re-entered the cycle after RESP; a new access can be accepted there (back-to-back allowed).
- bus2ip_addr_o and bus2ip_data_o hold their values from latch until the next accepted access.
- err_cnt_o increments on every RESP with slverr=1 and saturates at all-ones. last_err_o updates on the same cycle.
- Reset during a transaction clears everything immediately; the in-flight transfer returns no ready.

Decomposition:
- ptpv2_defines.v: FSM state encodings, error-cause bit positions, default CH_LSB.
- Sub-module pbus_ch_dec: combinational decode of ch to a one-hot vector plus out-of-range flag, and the rdata slice mux. The FSM and counters live in the top module.

Test Plan:
- Write ch1, addr 0x0001_0010, data 0xA5A5, ack in REQ -> wr_ce_o=4'b0010 for 1 cycle, bus2ip_addr_o=0x0010, bus2ip_data_o=0xA5A5, ready at T+2, slverr=0.
- Read ch2, ack 3 cycles after ce with data 0x1234 -> rd_ce_o=4'b0100 once, rdata=0x0000_1234, ready at T+5, slverr=0.
- Read ch3, no ack, TIMEOUT=15 -> ready at T+16, slverr=1, rdata=0, err_cnt_o=1, last_err_o=2'b10.
- NUM_CH=3, access addr 0x0003_0000 or addr 0x0000_0002 -> no ce, ready at T+1, slverr=1, last_err_o=2'b01; err_cnt saturates at 255 after 300 such errors.
- Back-to-back reads on ch0 then ch1 with acks in REQ -> two ready pulses 3 cycles apart, correct per-channel data; an ack on ch1 during the ch0 transfer is ignored.
- Assert pbus_rst in WAIT, or drop pbus_sel_i in WAIT -> no ready pulse, state IDLE, all ce 0; next access completes normally.

Source files
------------

// File: rtl/pbus_mc_bridge_pkg.sv
// Shared types and constants for the multi-channel peripheral bus bridge.
package pbus_mc_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } state_e;

  // Bit positions inside last_err_o = {timeout, decode}.
  localparam int unsigned ErrDecBit = 0;
  localparam int unsigned ErrToBit  = 1;

  localparam int unsigned DefChLsb = 16;

  // Channel-select field width; at least one bit even for a single channel.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pbus_ch_dec.sv
// Channel decoder: one-hot select, out-of-range flag and read-data slice mux.
module pbus_ch_dec #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_W   = 2
) (
  input  logic [CH_W-1:0]          ch_i,
  input  logic [NUM_CH*DATA_W-1:0] ip2bus_data_i,
  output logic [NUM_CH-1:0]        ch_onehot_o,
  output logic                     ch_oor_o,
  output logic [DATA_W-1:0]        ch_rdata_o
);

  // Match the channel index against every implemented channel.
  always_comb begin
    ch_onehot_o = '0;
    ch_oor_o    = 1'b1;
    ch_rdata_o  = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (ch_i == CH_W'(k)) begin
        ch_onehot_o[k] = 1'b1;
        ch_oor_o       = 1'b0;
        ch_rdata_o     = ip2bus_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/pbus_mc_bridge.sv
// APB-like slave to NUM_CH IP register channels with decode/timeout errors.
module pbus_mc_bridge
  import pbus_mc_bridge_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned CH_LSB   = DefChLsb,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                     pbus_clk,
  input  logic                     pbus_rst,
  input  logic [31:0]              pbus_addr_i,
  input  logic                     pbus_write_i,
  input  logic                     pbus_sel_i,
  input  logic                     pbus_enable_i,
  input  logic [31:0]              pbus_wdata_i,
  output logic [31:0]              pbus_rdata_o,
  output logic                     pbus_ready_o,
  output logic                     pbus_slverr_o,
  output logic [ADDR_W-1:0]        bus2ip_addr_o,
  output logic [DATA_W-1:0]        bus2ip_data_o,
  output logic [NUM_CH-1:0]        bus2ip_rd_ce_o,
  output logic [NUM_CH-1:0]        bus2ip_wr_ce_o,
  input  logic [NUM_CH*DATA_W-1:0] ip2bus_data_i,
  input  logic [NUM_CH-1:0]        ip2bus_ack_i,
  output logic [ERRCNT_W-1:0]      err_cnt_o,
  output logic [1:0]               last_err_o
);

  localparam int unsigned CH_W = ch_width(NUM_CH);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                slverr_q, slverr_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]          last_err_q, last_err_d;

  logic [CH_W-1:0]     dec_ch;
  logic [NUM_CH-1:0]   dec_onehot;
  logic                dec_oor;
  logic [DATA_W-1:0]   dec_rdata;
  logic                ack_sel;
  logic                err_evt;
  logic [1:0]          err_cause;
  logic                unused_inputs;

  // Address bits outside the local and channel fields are don't-care.
  assign unused_inputs = ^{pbus_addr_i, pbus_wdata_i};

  // In IDLE decode the incoming address; afterwards the latched channel.
  assign dec_ch = (state_q == StIdle) ? pbus_addr_i[CH_LSB +: CH_W] : ch_q;

  pbus_ch_dec #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CH_W   (CH_W)
  ) u_ch_dec (
    .ch_i          (dec_ch),
    .ip2bus_data_i (ip2bus_data_i),
    .ch_onehot_o   (dec_onehot),
    .ch_oor_o      (dec_oor),
    .ch_rdata_o    (dec_rdata)
  );

  // Only the selected channel's acknowledge is considered.
  assign ack_sel = |(ip2bus_ack_i & dec_onehot);

  // Next-state, latch and error bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    ch_d       = ch_q;
    to_cnt_d   = to_cnt_q;
    rdata_d    = rdata_q;
    slverr_d   = slverr_q;
    err_cnt_d  = err_cnt_q;
    last_err_d = last_err_q;
    err_evt    = 1'b0;
    err_cause  = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (pbus_sel_i && pbus_enable_i) begin
          addr_d   = pbus_addr_i[ADDR_W-1:0];
          wdata_d  = pbus_wdata_i[DATA_W-1:0];
          write_d  = pbus_write_i;
          ch_d     = pbus_addr_i[CH_LSB +: CH_W];
          rdata_d  = '0;
          slverr_d = 1'b0;
          if (dec_oor || (pbus_addr_i[1:0] != 2'b00)) begin
            state_d              = StResp;
            err_evt              = 1'b1;
            err_cause[ErrDecBit] = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        to_cnt_d = '0;
        if (!pbus_sel_i) begin
          state_d = StIdle;
        end else if (ack_sel) begin
          state_d = StResp;
          if (!write_q) rdata_d = dec_rdata;
        end else if (TIMEOUT == 1) begin
          state_d             = StResp;
          err_evt             = 1'b1;
          err_cause[ErrToBit] = 1'b1;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (!pbus_sel_i) begin
          state_d = StIdle;
        end else if (ack_sel) begin
          state_d = StResp;
          if (!write_q) rdata_d = dec_rdata;
        end else if (to_cnt_d == TO_W'(TIMEOUT - 1)) begin
          state_d             = StResp;
          err_evt             = 1'b1;
          err_cause[ErrToBit] = 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Error status becomes visible together with the ready pulse.
    if (err_evt) begin
      slverr_d   = 1'b1;
      rdata_d    = '0;
      last_err_d = err_cause;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge pbus_clk or posedge pbus_rst) begin
    if (pbus_rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      ch_q       <= '0;
      to_cnt_q   <= '0;
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
      err_cnt_q  <= '0;
      last_err_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      ch_q       <= ch_d;
      to_cnt_q   <= to_cnt_d;
      rdata_q    <= rdata_d;
      slverr_q   <= slverr_d;
      err_cnt_q  <= err_cnt_d;
      last_err_q <= last_err_d;
    end
  end

  // Strobes fire only in REQ, on the latched channel.
  always_comb begin
    bus2ip_rd_ce_o = '0;
    bus2ip_wr_ce_o = '0;
    if (state_q == StReq) begin
      if (write_q) bus2ip_wr_ce_o = dec_onehot;
      else         bus2ip_rd_ce_o = dec_onehot;
    end
  end

  assign pbus_ready_o  = (state_q == StResp);
  assign pbus_rdata_o  = (state_q == StResp) ? 32'(rdata_q) : 32'd0;
  assign pbus_slverr_o = (state_q == StResp) & slverr_q;
  assign bus2ip_addr_o = addr_q;
  assign bus2ip_data_o = wdata_q;
  assign err_cnt_o     = err_cnt_q;
  assign last_err_o    = last_err_q;

endmodule

// File: tb/tb_pbus_mc_bridge.sv
// Directed bench for pbus_mc_bridge with a response scoreboard per instance.
module tb_pbus_mc_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        write = 1'b0;
  logic        sel = 1'b0;
  logic        sel3 = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] ip_data = '0;
  logic [3:0]  ip_ack = '0;

  logic [31:0] rdata, rdata3;
  logic        rdy, rdy3, slverr, slverr3;
  logic [15:0] b_addr, b_addr3, b_data, b_data3;
  logic [3:0]  rd_ce, wr_ce;
  logic [2:0]  rd_ce3, wr_ce3;
  logic [7:0]  err_cnt, err_cnt3;
  logic [1:0]  last_err, last_err3;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int t;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];
  exp_t mon_e, mon_e3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pbus_mc_bridge #(
    .NUM_CH (4), .DATA_W (16), .ADDR_W (16), .CH_LSB (16), .TIMEOUT (15), .ERRCNT_W (8)
  ) u_dut (
    .pbus_clk (clk), .pbus_rst (rst), .pbus_addr_i (addr), .pbus_write_i (write),
    .pbus_sel_i (sel), .pbus_enable_i (enable), .pbus_wdata_i (wdata),
    .pbus_rdata_o (rdata), .pbus_ready_o (rdy), .pbus_slverr_o (slverr),
    .bus2ip_addr_o (b_addr), .bus2ip_data_o (b_data), .bus2ip_rd_ce_o (rd_ce),
    .bus2ip_wr_ce_o (wr_ce), .ip2bus_data_i (ip_data), .ip2bus_ack_i (ip_ack),
    .err_cnt_o (err_cnt), .last_err_o (last_err)
  );

  pbus_mc_bridge #(
    .NUM_CH (3), .DATA_W (16), .ADDR_W (16), .CH_LSB (16), .TIMEOUT (15), .ERRCNT_W (8)
  ) u_dut3 (
    .pbus_clk (clk), .pbus_rst (rst), .pbus_addr_i (addr), .pbus_write_i (write),
    .pbus_sel_i (sel3), .pbus_enable_i (enable), .pbus_wdata_i (wdata),
    .pbus_rdata_o (rdata3), .pbus_ready_o (rdy3), .pbus_slverr_o (slverr3),
    .bus2ip_addr_o (b_addr3), .bus2ip_data_o (b_data3), .bus2ip_rd_ce_o (rd_ce3),
    .bus2ip_wr_ce_o (wr_ce3), .ip2bus_data_i (48'hFFFF_FFFF_FFFF), .ip2bus_ack_i (3'b000),
    .err_cnt_o (err_cnt3), .last_err_o (last_err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rdy) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 32'(rdy), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rdata", rdata, mon_e.rdata);
        chk("slverr", 32'(slverr), 32'(mon_e.slverr));
        chk("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rdy3) begin
      if (sb3.size() == 0) begin
        chk("spurious_ready3", 32'(rdy3), 32'd0);
      end else begin
        mon_e3 = sb3.pop_front();
        chk("rdata3", rdata3, mon_e3.rdata);
        chk("slverr3", 32'(slverr3), 32'(mon_e3.slverr));
        chk("ready_cycle3", 32'(cyc), 32'(mon_e3.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit d3, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, output int tt);
    addr   = a;
    write  = w;
    wdata  = wd;
    enable = 1'b1;
    if (d3) sel3 = 1'b1;
    else    sel  = 1'b1;
    tt = cyc;
  endtask

  task automatic expect_rsp(input bit d3, input logic [31:0] rd, input logic se, input int c);
    exp_t e;
    e.rdata  = rd;
    e.slverr = se;
    e.cyc    = c;
    if (d3) sb3.push_back(e);
    else    sb.push_back(e);
  endtask

  task automatic wait_ready(input bit d3, input int max);
    int n = 0;
    logic r;
    do begin
      @(negedge clk);
      n++;
      r = d3 ? rdy3 : rdy;
    end while (!r && n < max);
    chk("ready_seen", 32'(r), 32'd1);
    chk("no_ce_in_resp", d3 ? 32'({rd_ce3, wr_ce3}) : 32'({rd_ce, wr_ce}), 32'd0);
    next_cycle();
    sel    = 1'b0;
    sel3   = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_slverr", 32'(slverr), 32'd0);
    chk("rst_ce", 32'({rd_ce, wr_ce}), 32'd0);
    chk("rst_baddr", 32'(b_addr), 32'd0);
    chk("rst_bdata", 32'(b_data), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_lasterr", 32'(last_err), 32'd0);
    rst = 1'b0;
    next_cycle();

    // Write ch1, ack in REQ.
    start(0, 32'h0001_0010, 1'b1, 32'hFFFF_A5A5, t);
    expect_rsp(0, 32'd0, 1'b0, t + 2);
    next_cycle();
    ip_ack = 4'b0010;
    @(negedge clk);
    chk("wr_ce_ch1", 32'(wr_ce), 32'h2);
    chk("rd_ce_on_write", 32'(rd_ce), 32'h0);
    chk("bus2ip_addr", 32'(b_addr), 32'h0010);
    chk("bus2ip_data", 32'(b_data), 32'hA5A5);
    next_cycle();
    ip_ack = '0;
    wait_ready(0, 8);

    // Read ch2, ack three cycles after the strobe; data changes afterwards.
    start(0, 32'h0002_0004, 1'b0, 32'd0, t);
    expect_rsp(0, 32'h0000_1234, 1'b0, t + 5);
    next_cycle();
    @(negedge clk);
    chk("rd_ce_ch2", 32'(rd_ce), 32'h4);
    next_cycle();
    @(negedge clk);
    chk("rd_ce_once", 32'(rd_ce), 32'h0);
    next_cycle();
    next_cycle();
    ip_data[32 +: 16] = 16'h1234;
    ip_ack = 4'b0100;
    next_cycle();
    ip_ack = '0;
    ip_data[32 +: 16] = 16'hDEAD;
    wait_ready(0, 8);

    // Read ch3 with no ack (a foreign ack on ch2 must be ignored).
    ip_data[48 +: 16] = 16'h5A5A;
    start(0, 32'h0003_0008, 1'b0, 32'd0, t);
    expect_rsp(0, 32'd0, 1'b1, t + 16);
    next_cycle();
    ip_ack = 4'b0100;
    wait_ready(0, 40);
    ip_ack = '0;
    chk("errcnt_after_timeout", 32'(err_cnt), 32'd1);
    chk("lasterr_timeout", 32'(last_err), 32'h2);

    // Back-to-back reads ch0 then ch1; ch1 ack during ch0 is ignored.
    ip_data[0 +: 16]  = 16'h1111;
    ip_data[16 +: 16] = 16'h2222;
    start(0, 32'h0000_0020, 1'b0, 32'd0, t);
    expect_rsp(0, 32'h0000_1111, 1'b0, t + 2);
    expect_rsp(0, 32'h0000_2222, 1'b0, t + 5);
    next_cycle();
    ip_ack = 4'b0011;
    next_cycle();
    ip_ack = '0;
    wait_ready(0, 8);
    start(0, 32'h0001_0024, 1'b0, 32'd0, t);
    next_cycle();
    ip_ack = 4'b0010;
    next_cycle();
    ip_ack = '0;
    wait_ready(0, 8);

    // Abort in WAIT by dropping sel; a late ack must not complete anything.
    start(0, 32'h0000_0030, 1'b0, 32'd0, t);
    next_cycle();
    next_cycle();
    sel    = 1'b0;
    enable = 1'b0;
    next_cycle();
    ip_ack = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(rdy), 32'd0);
      chk("abort_no_ce", 32'({rd_ce, wr_ce}), 32'd0);
      next_cycle();
    end
    ip_ack = '0;
    chk("abort_errcnt", 32'(err_cnt), 32'd1);
    start(0, 32'h0002_0040, 1'b1, 32'h0000_BEEF, t);
    expect_rsp(0, 32'd0, 1'b0, t + 2);
    next_cycle();
    ip_ack = 4'b0100;
    @(negedge clk);
    chk("post_abort_wr_ce", 32'(wr_ce), 32'h4);
    chk("post_abort_data", 32'(b_data), 32'hBEEF);
    next_cycle();
    ip_ack = '0;
    wait_ready(0, 8);

    // Asynchronous reset in WAIT.
    start(0, 32'h0001_0050, 1'b0, 32'd0, t);
    next_cycle();
    next_cycle();
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(rdy), 32'd0);
    chk("arst_ce", 32'({rd_ce, wr_ce}), 32'd0);
    chk("arst_errcnt", 32'(err_cnt), 32'd0);
    chk("arst_lasterr", 32'(last_err), 32'd0);
    chk("arst_baddr", 32'(b_addr), 32'd0);
    sel    = 1'b0;
    enable = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    start(0, 32'h0001_0054, 1'b0, 32'd0, t);
    expect_rsp(0, 32'h0000_2222, 1'b0, t + 2);
    next_cycle();
    ip_ack = 4'b0010;
    next_cycle();
    ip_ack = '0;
    wait_ready(0, 8);

    // Decode errors on the three-channel instance, then counter saturation.
    start(1, 32'h0003_0000, 1'b0, 32'd0, t);
    expect_rsp(1, 32'd0, 1'b1, t + 1);
    wait_ready(1, 4);
    chk("dec_lasterr", 32'(last_err3), 32'h1);
    chk("dec_errcnt1", 32'(err_cnt3), 32'd1);
    start(1, 32'h0000_0002, 1'b1, 32'h0000_0001, t);
    expect_rsp(1, 32'd0, 1'b1, t + 1);
    wait_ready(1, 4);
    chk("misalign_errcnt2", 32'(err_cnt3), 32'd2);
    chk("misalign_lasterr", 32'(last_err3), 32'h1);
    for (int i = 0; i < 298; i++) begin
      start(1, 32'h0003_0000, 1'b0, 32'd0, t);
      expect_rsp(1, 32'd0, 1'b1, t + 1);
      wait_ready(1, 4);
    end
    chk("errcnt_saturated", 32'(err_cnt3), 32'd255);

    repeat (3) next_cycle();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb3_drained", 32'(sb3.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
